// File: rtl/mem_copy_pkg.sv
// Shared definitions for the memory copy/fill engine: address width and FSM state encoding.
package mem_copy_pkg;

  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// Streams length words from a source memory to a destination memory (copy), or writes a
// latched constant (fill), one word per cycle with the write trailing its read by one cycle.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int width = 16
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic              start,
  input  logic              fill,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [width-1:0]  fill_value,
  input  logic              abort,
  output logic [ADDR_W-1:0] src_rdaddress,
  input  logic [width-1:0]  src_q,
  output logic [ADDR_W-1:0] dst_wraddress,
  output logic              dst_wren,
  output logic [width-1:0]  dst_data,
  output logic              busy,
  output logic              done
);

  state_e              state_q;
  logic [ADDR_W-1:0]   src_rd_q, src_rd_d;
  logic [ADDR_W-1:0]   dst_wr_q;
  logic [ADDR_W-1:0]   dst_next_q, dst_next_d;
  logic [ADDR_W-1:0]   remain_q, remain_d;
  logic                fill_q;
  logic [width-1:0]    fill_value_q;
  logic                wren_q;
  logic                busy_q;
  logic                done_q;

  // Address counters wrap naturally at 2^16.
  always_comb begin
    src_rd_d   = src_rd_q + ADDR_W'(1);
    dst_next_d = dst_next_q + ADDR_W'(1);
    remain_d   = remain_q - ADDR_W'(1);
  end

  always_ff @(posedge clock) begin
    if (aclr) begin
      state_q      <= IDLE;
      src_rd_q     <= '0;
      dst_wr_q     <= '0;
      dst_next_q   <= '0;
      remain_q     <= '0;
      fill_q       <= 1'b0;
      fill_value_q <= '0;
      wren_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          wren_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            if (length != '0) begin
              src_rd_q     <= src_addr;
              dst_next_q   <= dst_addr;
              remain_q     <= length;
              fill_q       <= fill;
              fill_value_q <= fill_value;
              busy_q       <= 1'b1;
              state_q      <= RUN;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        RUN: begin
          if (abort) begin
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            // The read issued this cycle becomes the write of the next cycle.
            wren_q     <= 1'b1;
            dst_wr_q   <= dst_next_q;
            dst_next_q <= dst_next_d;
            src_rd_q   <= src_rd_d;
            remain_q   <= remain_d;
            if (remain_q == ADDR_W'(1)) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          wren_q <= 1'b0;
          busy_q <= 1'b0;
          if (abort) begin
            state_q <= IDLE;
          end else begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign src_rdaddress = src_rd_q;
  assign dst_wraddress = dst_wr_q;
  assign dst_wren      = wren_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign dst_data      = fill_q ? fill_value_q : src_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: a behavioural source memory feeds the DUT and a
// negedge monitor logs writes, busy and done cycles, which each scenario compares with its model.
module tb_mem_copy_engine;

  logic        clock;
  logic        aclr;
  logic        start;
  logic        fill;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] length;
  logic [15:0] fill_value;
  logic        abort;
  logic [15:0] src_rdaddress;
  logic [15:0] src_q;
  logic [15:0] dst_wraddress;
  logic        dst_wren;
  logic [15:0] dst_data;
  logic        busy;
  logic        done;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic [15:0] srcMem [0:65535];
  wr_t         wrLog[$];
  int          busyLog[$];
  logic [15:0] rdLog[$];
  int          doneLog[$];
  wr_t         wrEntry;
  int          cycle = 0;
  int          checks = 0;
  int          errors = 0;

  mem_copy_engine #(.width(16)) dut (
    .clock        (clock),
    .aclr         (aclr),
    .start        (start),
    .fill         (fill),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .length       (length),
    .fill_value   (fill_value),
    .abort        (abort),
    .src_rdaddress(src_rdaddress),
    .src_q        (src_q),
    .dst_wraddress(dst_wraddress),
    .dst_wren     (dst_wren),
    .dst_data     (dst_data),
    .busy         (busy),
    .done         (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  // Synchronous-read source memory: q is valid one cycle after its address.
  always @(posedge clock) src_q <= srcMem[src_rdaddress];

  always @(negedge clock) begin
    if (dst_wren === 1'b1) begin
      wrEntry.cyc  = cycle;
      wrEntry.addr = dst_wraddress;
      wrEntry.data = dst_data;
      wrLog.push_back(wrEntry);
    end
    if (busy === 1'b1) begin
      busyLog.push_back(cycle);
      rdLog.push_back(src_rdaddress);
    end
    if (done === 1'b1) doneLog.push_back(cycle);
  end

  task automatic startTransfer(input logic f, input logic [15:0] s, input logic [15:0] d,
                               input logic [15:0] len, input logic [15:0] fv, output int t);
    @(negedge clock);
    wrLog.delete();
    busyLog.delete();
    rdLog.delete();
    doneLog.delete();
    fill       = f;
    src_addr   = s;
    dst_addr   = d;
    length     = len;
    fill_value = fv;
    start      = 1'b1;
    t          = cycle;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Full transfer against the model: word k is read at T+1+k, written at T+2+k, done at T+len+2.
  task automatic do_transfer(input string name, input logic f, input logic [15:0] s,
                             input logic [15:0] d, input logic [15:0] len, input logic [15:0] fv);
    int          t;
    int          nb;
    int          expDone;
    logic [15:0] ea;
    logic [15:0] ed;
    logic [15:0] er;
    startTransfer(f, s, d, len, fv, t);
    repeat (int'(len) + 4) @(negedge clock);
    nb      = (len == 16'd0) ? 0 : int'(len) + 1;
    expDone = (len == 16'd0) ? t + 1 : t + int'(len) + 2;
    checks++;
    if (wrLog.size() != int'(len)) begin
      errors++;
      $display("[TB] FAIL %s write count: got %0d expected %0d", name, wrLog.size(), len);
    end
    for (int k = 0; k < int'(len) && k < wrLog.size(); k++) begin
      ea = d + 16'(k);
      er = s + 16'(k);
      ed = f ? fv : srcMem[er];
      checks++;
      if (wrLog[k].cyc != t + 2 + k || wrLog[k].addr !== ea || wrLog[k].data !== ed) begin
        errors++;
        $display("[TB] FAIL %s write %0d: got cyc=%0d addr=%h data=%h expected cyc=%0d addr=%h data=%h",
                 name, k, wrLog[k].cyc, wrLog[k].addr, wrLog[k].data, t + 2 + k, ea, ed);
      end
    end
    for (int k = 0; k < int'(len) && k < rdLog.size(); k++) begin
      er = s + 16'(k);
      checks++;
      if (rdLog[k] !== er) begin
        errors++;
        $display("[TB] FAIL %s read %0d: got %h expected %h", name, k, rdLog[k], er);
      end
    end
    checks++;
    if (busyLog.size() != nb) begin
      errors++;
      $display("[TB] FAIL %s busy cycles: got %0d expected %0d", name, busyLog.size(), nb);
    end
    if (busyLog.size() > 0) begin
      checks++;
      if (busyLog[0] != t + 1) begin
        errors++;
        $display("[TB] FAIL %s busy start: got %0d expected %0d", name, busyLog[0], t + 1);
      end
    end
    checks++;
    if (doneLog.size() != 1 || doneLog[0] != expDone) begin
      errors++;
      $display("[TB] FAIL %s done: got %0d pulses (first %0d) expected 1 at %0d",
               name, doneLog.size(), (doneLog.size() > 0) ? doneLog[0] : -1, expDone);
    end
  endtask

  task automatic test_reset();
    aclr = 1'b1;
    repeat (2) @(negedge clock);
    checks += 5;
    if (busy !== 1'b0)              begin errors++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
    if (done !== 1'b0)              begin errors++; $display("[TB] FAIL reset done: got %b expected 0", done); end
    if (dst_wren !== 1'b0)          begin errors++; $display("[TB] FAIL reset wren: got %b expected 0", dst_wren); end
    if (src_rdaddress !== 16'h0000) begin errors++; $display("[TB] FAIL reset rdaddr: got %h expected 0000", src_rdaddress); end
    if (dst_wraddress !== 16'h0000) begin errors++; $display("[TB] FAIL reset wraddr: got %h expected 0000", dst_wraddress); end
    aclr = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_copy();
    for (int i = 0; i < 4; i++) srcMem[16'h0100 + i] = 16'h00A0 + 16'(i);
    do_transfer("copy", 1'b0, 16'h0100, 16'h0200, 16'd4, 16'h0000);
  endtask

  task automatic test_fill();
    do_transfer("fill", 1'b1, 16'h5555, 16'h0010, 16'd3, 16'hBEEF);
  endtask

  task automatic test_wrap();
    do_transfer("wrap", 1'b0, 16'hFFFE, 16'hFFFF, 16'd3, 16'h0000);
  endtask

  task automatic test_zero_length();
    do_transfer("zero", 1'b0, 16'h1234, 16'h4321, 16'd0, 16'h0000);
  endtask

  // Abort during the third RUN cycle: only words 0 and 1 reach the destination.
  task automatic test_abort();
    int t;
    startTransfer(1'b0, 16'h0300, 16'h3000, 16'd8, 16'h0000, t);
    repeat (2) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    repeat (10) @(negedge clock);
    checks++;
    if (wrLog.size() != 2) begin
      errors++;
      $display("[TB] FAIL abort write count: got %0d expected 2", wrLog.size());
    end
    for (int k = 0; k < 2 && k < wrLog.size(); k++) begin
      checks++;
      if (wrLog[k].addr !== 16'h3000 + 16'(k) || wrLog[k].data !== srcMem[16'h0300 + 16'(k)]
          || wrLog[k].cyc != t + 2 + k) begin
        errors++;
        $display("[TB] FAIL abort write %0d: got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                 k, wrLog[k].addr, wrLog[k].data, wrLog[k].cyc, 16'h3000 + 16'(k),
                 srcMem[16'h0300 + 16'(k)], t + 2 + k);
      end
    end
    checks += 2;
    if (doneLog.size() != 0) begin
      errors++;
      $display("[TB] FAIL abort done: got %0d pulses expected 0", doneLog.size());
    end
    if (busyLog.size() != 3) begin
      errors++;
      $display("[TB] FAIL abort busy cycles: got %0d expected 3", busyLog.size());
    end
    do_transfer("after_abort", 1'b0, 16'h0600, 16'h6000, 16'd5, 16'h0000);
  endtask

  task automatic test_reset_mid();
    int t;
    startTransfer(1'b1, 16'h0700, 16'h0800, 16'd6, 16'hCAFE, t);
    @(negedge clock);
    aclr = 1'b1;
    @(negedge clock);
    checks += 5;
    if (busy !== 1'b0)              begin errors++; $display("[TB] FAIL midreset busy: got %b expected 0", busy); end
    if (done !== 1'b0)              begin errors++; $display("[TB] FAIL midreset done: got %b expected 0", done); end
    if (dst_wren !== 1'b0)          begin errors++; $display("[TB] FAIL midreset wren: got %b expected 0", dst_wren); end
    if (src_rdaddress !== 16'h0000) begin errors++; $display("[TB] FAIL midreset rdaddr: got %h expected 0000", src_rdaddress); end
    if (dst_wraddress !== 16'h0000) begin errors++; $display("[TB] FAIL midreset wraddr: got %h expected 0000", dst_wraddress); end
    aclr = 1'b0;
    repeat (8) @(negedge clock);
    checks += 2;
    if (wrLog.size() != 1) begin
      errors++;
      $display("[TB] FAIL midreset write count: got %0d expected 1", wrLog.size());
    end
    if (doneLog.size() != 0) begin
      errors++;
      $display("[TB] FAIL midreset done: got %0d pulses expected 0", doneLog.size());
    end
  endtask

  // A second start with different parameters while busy must not disturb the running transfer.
  task automatic test_ignored_start();
    int t;
    startTransfer(1'b0, 16'h0400, 16'h0500, 16'd5, 16'h0000, t);
    fill       = 1'b1;
    src_addr   = 16'h9000;
    dst_addr   = 16'h9100;
    length     = 16'd2;
    fill_value = 16'h1234;
    start      = 1'b1;
    repeat (3) @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    checks++;
    if (wrLog.size() != 5) begin
      errors++;
      $display("[TB] FAIL ignstart write count: got %0d expected 5", wrLog.size());
    end
    for (int k = 0; k < 5 && k < wrLog.size(); k++) begin
      checks++;
      if (wrLog[k].addr !== 16'h0500 + 16'(k) || wrLog[k].data !== srcMem[16'h0400 + 16'(k)]) begin
        errors++;
        $display("[TB] FAIL ignstart write %0d: got addr=%h data=%h expected addr=%h data=%h",
                 k, wrLog[k].addr, wrLog[k].data, 16'h0500 + 16'(k), srcMem[16'h0400 + 16'(k)]);
      end
    end
    checks += 2;
    if (busyLog.size() != 6) begin
      errors++;
      $display("[TB] FAIL ignstart busy cycles: got %0d expected 6", busyLog.size());
    end
    if (doneLog.size() != 1 || doneLog[0] != t + 7) begin
      errors++;
      $display("[TB] FAIL ignstart done: got %0d pulses expected 1 at %0d", doneLog.size(), t + 7);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      do_transfer("random", 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                  16'($urandom_range(0, 12)), 16'($urandom));
    end
  endtask

  initial begin
    aclr       = 1'b1;
    start      = 1'b0;
    fill       = 1'b0;
    src_addr   = '0;
    dst_addr   = '0;
    length     = '0;
    fill_value = '0;
    abort      = 1'b0;
    for (int i = 0; i < 65536; i++) srcMem[i] = 16'($urandom);
    test_reset();
    test_copy();
    test_fill();
    test_wrap();
    test_zero_length();
    test_abort();
    test_reset_mid();
    test_ignored_start();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
